// File: rtl/down_counter_param.sv
// ---------------------------------------------------------------------------
// down_counter_param
// Parametrised, cascadable, loadable down counter with a programmable reload
// value and a one-shot mode. Stages cascade by feeding co into the next cnt.
// Optional build macro: DOWN_COUNTER_PARAM_UPDN_EN adds an up_dn input that
// selects up counting (terminal at reload, wrap to zero).
// ---------------------------------------------------------------------------
module down_counter_param #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             mode,
`ifdef DOWN_COUNTER_PARAM_UPDN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] count,
  output logic             co,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic             done_r;
  logic             tc_r;

  logic             term_s;
  logic [WIDTH-1:0] wrap_s;
  logic [WIDTH-1:0] step_s;
  logic             co_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] reload_nxt_s;
  logic             done_nxt_s;

  // Direction-dependent terminal condition, wrap target and single step.
  always_comb begin
    term_s = (count_r == ZERO);
    wrap_s = reload_r;
    step_s = count_r - ONE;
`ifdef DOWN_COUNTER_PARAM_UPDN_EN
    if (up_dn) begin
      term_s = (count_r == reload_r);
      wrap_s = ZERO;
      step_s = count_r + ONE;
    end else begin
      term_s = (count_r == ZERO);
      wrap_s = reload_r;
      step_s = count_r - ONE;
    end
`endif
  end

  // Carry-out is combinational so a cascaded stage sees it in the same cycle.
  always_comb begin
    co_s = cnt & ~ld & ~done_r & term_s;
  end

  // Next-state selection: load beats count, a finished one-shot ignores cnt.
  always_comb begin
    count_nxt_s  = count_r;
    reload_nxt_s = reload_r;
    done_nxt_s   = done_r;
    if (ld) begin
      count_nxt_s  = ld_val;
      reload_nxt_s = ld_val;
      done_nxt_s   = 1'b0;
    end else if (cnt && !done_r) begin
      if (term_s) begin
        if (mode) begin
          // One-shot: park at the terminal value and flag completion.
          count_nxt_s = count_r;
          done_nxt_s  = 1'b1;
        end else begin
          count_nxt_s = wrap_s;
          done_nxt_s  = 1'b0;
        end
      end else begin
        count_nxt_s = step_s;
        done_nxt_s  = 1'b0;
      end
    end else begin
      count_nxt_s  = count_r;
      reload_nxt_s = reload_r;
      done_nxt_s   = done_r;
    end
  end

  // State registers; reset restores both count and reload to RESET_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= RESET_VAL;
      reload_r <= RESET_VAL;
      done_r   <= 1'b0;
      tc_r     <= 1'b0;
    end else begin
      count_r  <= count_nxt_s;
      reload_r <= reload_nxt_s;
      done_r   <= done_nxt_s;
      tc_r     <= co_s;
    end
  end

  assign count = count_r;
  assign co    = co_s;
  assign tc    = tc_r;
  assign done  = done_r;

endmodule

// File: tb/tb_down_counter_param.sv
// ---------------------------------------------------------------------------
// tb_down_counter_param
// Table-driven bench for down_counter_param (WIDTH=4, default RESET_VAL=15).
// co is checked before each edge; post-edge count/tc/done expectations are
// queued when a vector is driven and popped after the edge.
// ---------------------------------------------------------------------------
module tb_down_counter_param;

  logic       clk;
  logic       rst;
  logic       cnt;
  logic       ld;
  logic [3:0] ld_val;
  logic       mode;
  logic       up_dn;
  logic [3:0] count;
  logic       co;
  logic       tc;
  logic       done;

  int total;
  int bad;

  typedef struct {
    logic       cnt;
    logic       ld;
    logic [3:0] ld_val;
    logic       mode;
    logic       exp_co;
    logic [3:0] exp_count;
    logic       exp_tc;
    logic       exp_done;
  } vec_t;

  typedef struct {
    logic [3:0] count;
    logic       tc;
    logic       done;
  } exp_t;

  vec_t tbl[64];
  int   ntbl;
  exp_t sb[$];

  down_counter_param #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .cnt    (cnt),
    .ld     (ld),
    .ld_val (ld_val),
    .mode   (mode),
`ifdef DOWN_COUNTER_PARAM_UPDN_EN
    .up_dn  (up_dn),
`endif
    .count  (count),
    .co     (co),
    .tc     (tc),
    .done   (done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic add(input logic c, input logic l, input logic [3:0] lv,
                     input logic m, input logic eco, input logic [3:0] ecnt,
                     input logic etc, input logic edone);
    tbl[ntbl] = '{c, l, lv, m, eco, ecnt, etc, edone};
    ntbl++;
  endtask

  // Called just after a rising edge: drive, check co, queue post-edge state.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    cnt    = v.cnt;
    ld     = v.ld;
    ld_val = v.ld_val;
    mode   = v.mode;
    #1;
    chk({tag, ".co"}, int'(co), int'(v.exp_co));
    sb.push_back('{v.exp_count, v.exp_tc, v.exp_done});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".count"}, int'(count), int'(e.count));
      chk({tag, ".tc"},    int'(tc),    int'(e.tc));
      chk({tag, ".done"},  int'(done),  int'(e.done));
    end
  endtask

  // Raise rst between edges and confirm outputs change before the next edge.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    chk({tag, ".count"}, int'(count), 15);
    chk({tag, ".done"},  int'(done),  0);
    chk({tag, ".tc"},    int'(tc),    0);
    chk({tag, ".co"},    int'(co),    0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({tag, ".held"},  int'(count), 15);
  endtask

  initial begin
    vec_t v;
    total  = 0;
    bad    = 0;
    ntbl   = 0;
    rst    = 1'b1;
    cnt    = 1'b0;
    ld     = 1'b0;
    ld_val = 4'd0;
    mode   = 1'b0;
    up_dn  = 1'b0;

    // Periodic load 5: period of six cnt pulses, tc one cycle after co.
    add(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0);
      add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
      add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
      add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
    end
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0);
    // One-shot load 2: stops at 0, done sticks, cnt then ignored.
    add(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    // Switching back to periodic does not release a finished one-shot.
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    // Count to 0, then ld and cnt together at zero: load wins, no co.
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    // Hold when cnt is low.
    add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
    // Reload 0 gives co on every cnt cycle.
    add(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset.count", int'(count), 15);
    chk("reset.tc",    int'(tc),    0);
    chk("reset.done",  int'(done),  0);
    rst = 1'b0;
    #1;
    chk("reset.co", int'(co), 0);
    @(posedge clk);
    #1;

    // Full 16-step countdown from the reset value, wrap back to 15.
    for (int i = 0; i < 16; i++) begin
      v = '{1'b1, 1'b0, 4'd0, 1'b0, (i == 15), 4'(i == 15 ? 15 : 14 - i),
            (i == 15), 1'b0};
      apply(v, $sformatf("down16[%0d]", i));
    end
    v = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0};
    apply(v, "down16.after");

    // Vector table.
    for (int i = 0; i < ntbl; i++) begin
      apply(tbl[i], $sformatf("tbl[%0d]", i));
    end

    // Async reset with done and tc set.
    v = '{1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    apply(v, "rst1.ld");
    v = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1};
    apply(v, "rst1.fin");
    cnt = 1'b0;
    async_reset("rst1");

    // Async reset while count=7, then resume counting.
    v = '{1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0};
    apply(v, "rst2.ld");
    cnt = 1'b1;
    ld  = 1'b0;
    async_reset("rst2");
    v = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd14, 1'b0, 1'b0};
    apply(v, "rst2.resume");

`ifdef DOWN_COUNTER_PARAM_UPDN_EN
    // Up counting: load 3 wraps to 0 immediately, then 1,2,3 and wrap.
    up_dn = 1'b1;
    v = '{1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
    apply(v, "up.ld");
    v = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};
    apply(v, "up.wrap0");
    for (int i = 0; i < 3; i++) begin
      v = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'(i + 1), 1'b0, 1'b0};
      apply(v, $sformatf("up[%0d]", i));
    end
    v = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};
    apply(v, "up.wrap1");
    up_dn = 1'b0;
`endif

    chk("sb.drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
